tdm_demux4: RTL
===============

Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4:1 channel multiplexer.
- Accepts a time-division-multiplexed stream of 4-slot frames, delimited by a frame-sync strobe on slot 0.
- Steers each slot into its own registered channel output (1:4 demultiplex) and flags frame completion and framing errors.
- Sits between the serial/TDM link and the per-channel consumers.

Parameters:
WIDTH, 4, bit width of each slot sample and of each channel output

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  TDM slot sample
din_valid  input  1  din holds a valid slot this cycle
frame_sync  input  1  marks din as slot 0 of a new frame; ignored when din_valid=0
d0  output  WIDTH  last completed sample of channel 0
d1  output  WIDTH  last completed sample of channel 1
d2  output  WIDTH  last completed sample of channel 2
d3  output  WIDTH  last completed sample of channel 3
ch_strobe  output  4  one-hot, 1-cycle pulse; bit k set when dk was updated this cycle
frame_done  output  1  1-cycle pulse, coincident with the update of d3
frame_err  output  1  1-cycle pulse on a framing violation
sel  output  2  slot index expected for the next accepted sample (valid in RUN)
locked  output  1  1 while in RUN state

Behaviour:
- Reset (rst_n=0, asynchronous): d0..d3=0, ch_strobe=0, frame_done=0, frame_err=0, sel=0, locked=0, state=HUNT. The capture shadow registers are also cleared.
- All outputs are registered. A sample accepted at edge N appears on dk/ch_strobe after edge N, i.e. 1-cycle latency.
- "Accept" means din_valid=1 at a rising edge. Cycles with din_valid=0 are bubbles: no state change, strobes deasserted.
- HUNT state:
  - Valid with frame_sync=1: write din to d0, ch_strobe=0001, sel<=1, go to RUN.
  - Valid with frame_sync=0: sample dropped, no outputs change, no error (pre-lock noise).
- RUN state, valid sample with frame_sync=0: write din to d[sel], ch_strobe=onehot(sel), sel<=sel+1 (2-bit wrap).
  - When sel was 3: also pulse frame_done, set sel<=0, stay in RUN expecting the next frame's sync.
- RUN state, valid sample with frame_sync=1:
  - If sel==0: normal new frame; behaves as the sel==0 write.
  - If sel!=0 (premature sync, short frame): pulse frame_err, discard the partial frame position, write din to d0 with ch_strobe=0001, set sel<=1. No frame_done.
- RUN state, valid sample with sel==0 and frame_sync=0 (missing sync, long frame): pulse frame_err, drop the sample, go to HUNT, locked<=0, sel<=0.
- Channel outputs hold their value until overwritten. Channels already written in an aborted frame keep their new values.
- frame_done and frame_err are never asserted in the same cycle.
- Reset asserted mid-frame clears everything immediately. After release the block is in HUNT and the partial frame is lost.
- Back-to-back valids (every cycle) are supported at full rate: 1 sample per clock.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with din_valid toggling -> all outputs 0, locked=0; release -> still HUNT.
- Clean frame, WIDTH=4: send samples A,B,C,D on 4 consecutive valid cycles, sync on A -> d0=A, d1=B, d2=C, d3=D; ch_strobe pulses 0001, 0010, 0100, 1000; frame_done high only with D; locked=1; sel returns to 0.
- Bubbles and back-to-back frames: frame 1,2,3,4 with din_valid=0 gaps between slots, then frame 5,6,7,8 with no gap -> outputs 5,6,7,8; two frame_done pulses; no frame_err.
- Pre-lock noise: 3 valids with frame_sync=0 in HUNT -> no strobes, no error, d0..d3 unchanged; next valid with sync -> d0 updated, locked=1.
- Short frame: sync+1, 2, then sync+9 -> frame_err pulse on the third accept; d0=9; d1=2 retained; sel=1; no frame_done.
- Long frame and reset mid-frame: complete frame, then a valid without sync -> frame_err, locked=0. Separately, assert rst_n after slot 1 -> immediate clear; post-reset sample without sync is dropped.

Source files
------------

// File: rtl/tdm_demux4.sv
// 1:4 TDM demultiplexer: steers each slot of a 4-slot frame into its own channel register.
// Latency: 1 cycle from accepted sample to dk/ch_strobe/frame_done/frame_err.
// Backpressure: none; accepts one sample per clock, bubbles (din_valid=0) are held off.
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [3:0]       ch_strobe,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       sel,
    output logic             locked
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] d_q   [4];
    logic [WIDTH-1:0] d_nxt [4];
    logic [1:0]       sel_q, sel_nxt;
    logic [3:0]       strobe_q, strobe_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            sel_q    <= 2'd0;
            strobe_q <= 4'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            state_q  <= state_nxt;
            sel_q    <= sel_nxt;
            strobe_q <= strobe_nxt;
            done_q   <= done_nxt;
            err_q    <= err_nxt;
            for (int k = 0; k < 4; k++) begin
                d_q[k] <= d_nxt[k];
            end
        end
    end

    always_comb begin
        state_nxt  = state_q;
        sel_nxt    = sel_q;
        strobe_nxt = 4'd0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_nxt[k] = d_q[k];
        end

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Unsynced samples before lock are treated as line noise, not errors.
                    if (frame_sync) begin
                        d_nxt[0]   = din;
                        strobe_nxt = 4'b0001;
                        sel_nxt    = 2'd1;
                        state_nxt  = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // A sync mid-frame restarts at slot 0; partial channels keep their new values.
                        err_nxt    = (sel_q != 2'd0);
                        d_nxt[0]   = din;
                        strobe_nxt = 4'b0001;
                        sel_nxt    = 2'd1;
                    end else if (sel_q == 2'd0) begin
                        err_nxt   = 1'b1;
                        sel_nxt   = 2'd0;
                        state_nxt = HUNT;
                    end else begin
                        d_nxt[sel_q] = din;
                        strobe_nxt   = 4'b0001 << sel_q;
                        sel_nxt      = sel_q + 2'd1;
                        done_nxt     = (sel_q == 2'd3);
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    assign d0         = d_q[0];
    assign d1         = d_q[1];
    assign d2         = d_q[2];
    assign d3         = d_q[3];
    assign ch_strobe  = strobe_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign sel        = sel_q;
    assign locked     = (state_q == RUN);

endmodule
